// File: rtl/fwd_xform_pkg.sv
// Shared types and defaults for the forward-transform block sequencer.
// Holds the FSM state encoding and the default block geometry.
package fwd_xform_pkg;

  localparam int DIM_DEF    = 4;
  localparam int DATA_W_DEF = 9;
  localparam int RES_W_DEF  = 15;
  localparam int NUM_ELEM   = DIM_DEF * DIM_DEF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LAUNCH  = 3'd2,
    S_WAIT_DP = 3'd3,
    S_FINISH  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/transform_block_sequencer_rf_block_reader.sv
// Reads one DIM x DIM block from the register file, row-major,
// and assembles it into a flat sample vector for the datapath.
module rf_block_reader #(
  parameter int DATA_W = 9,
  parameter int DIM    = 4,
  parameter int ADDR_W = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          addr_i,
  output logic [ADDR_W-1:0]          rf_addr_o,
  output logic                       rf_en_o,
  input  logic [DATA_W-1:0]          rf_data_i,
  output logic [DIM*DIM*DATA_W-1:0]  x_flat_o,
  output logic                       done_o
);

  localparam int NE = DIM * DIM;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NE - 1);

  logic                        en_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [IW-1:0]               idx_q;
  logic                        cap_q;
  logic [IW-1:0]               cap_idx_q;
  logic [NE-1:0][DATA_W-1:0]   x_q;

  // Address generator: NE consecutive reads, wrapping mod 2^ADDR_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      idx_q  <= '0;
    end else if (start_i) begin
      en_q   <= 1'b1;
      addr_q <= addr_i;
      idx_q  <= '0;
    end else if (en_q) begin
      if (idx_q == LAST) begin
        en_q <= 1'b0;
      end else begin
        addr_q <= addr_q + ADDR_W'(1);
        idx_q  <= idx_q + IW'(1);
      end
    end
  end

  // Read data arrives one cycle after the address; write it to its slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
      x_q       <= '0;
    end else begin
      cap_q     <= en_q;
      cap_idx_q <= idx_q;
      if (cap_q) begin
        x_q[cap_idx_q] <= rf_data_i;
      end
    end
  end

  assign rf_addr_o = addr_q;
  assign rf_en_o   = en_q;
  assign x_flat_o  = x_q;
  assign done_o    = cap_q & (cap_idx_q == LAST);

endmodule

// File: rtl/transform_block_sequencer.sv
// Block sequencer: fetches blocks, launches the transform datapath
// and holds each result for the shell until it is accepted.
module transform_block_sequencer
  import fwd_xform_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int DIM    = DIM_DEF,
  parameter int ADDR_W = 6,
  parameter int BLK_W  = 3
) (
  input  logic                       in_clk,
  input  logic                       in_rst_n,
  input  logic                       in_start,
  input  logic [ADDR_W-1:0]          in_base_addr,
  input  logic [BLK_W-1:0]           in_num_blocks,
  output logic [ADDR_W-1:0]          out_rf_addr,
  output logic                       out_rf_en,
  input  logic [DATA_W-1:0]          in_rf_data,
  output logic [DIM*DIM*DATA_W-1:0]  out_x_flat,
  output logic                       out_dp_start,
  input  logic                       in_dp_done,
  input  logic [DIM*DIM*RES_W-1:0]   in_t_flat,
  output logic [DIM*DIM*RES_W-1:0]   out_t_flat,
  output logic                       out_t_valid,
  input  logic                       in_t_ready,
  output logic                       out_busy,
  output logic                       out_done
);

  localparam int NE = DIM * DIM;

  seq_state_e              state_q;
  logic [ADDR_W-1:0]       base_q;
  logic [BLK_W-1:0]        num_q;
  logic [BLK_W-1:0]        blk_q;
  logic                    done_q;
  logic [NE*RES_W-1:0]     t_flat_q;
  logic                    t_valid_q;

  logic                    rd_go;
  logic                    rd_done;
  logic                    reg_free;
  logic                    launch;
  logic                    load;
  logic                    more;
  logic [BLK_W:0]          blk_nxt;
  logic [ADDR_W-1:0]       nxt_addr;
  logic [ADDR_W-1:0]       rd_addr;

  assign reg_free = ~t_valid_q | in_t_ready;
  assign launch   = (state_q == S_LAUNCH) & reg_free;
  assign load     = (state_q == S_WAIT_DP) & in_dp_done;
  assign blk_nxt  = {1'b0, blk_q} + {{BLK_W{1'b0}}, 1'b1};
  assign more     = blk_nxt < {1'b0, num_q};
  assign nxt_addr = base_q + ADDR_W'(blk_nxt) * ADDR_W'(NE);
  assign rd_addr  = (state_q == S_IDLE) ? in_base_addr : nxt_addr;
  assign rd_go    = ((state_q == S_IDLE) & in_start
                    & (in_num_blocks != '0))
                  | (load & more);

  rf_block_reader #(
    .DATA_W (DATA_W),
    .DIM    (DIM),
    .ADDR_W (ADDR_W)
  ) u_reader (
    .clk_i     (in_clk),
    .rst_ni    (in_rst_n),
    .start_i   (rd_go),
    .addr_i    (rd_addr),
    .rf_addr_o (out_rf_addr),
    .rf_en_o   (out_rf_en),
    .rf_data_i (in_rf_data),
    .x_flat_o  (out_x_flat),
    .done_o    (rd_done)
  );

  // Run control: fetch, launch, wait for result, repeat, then finish.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      num_q   <= '0;
      blk_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_start) begin
            base_q  <= in_base_addr;
            num_q   <= in_num_blocks;
            blk_q   <= '0;
            state_q <= (in_num_blocks == '0) ? S_FINISH : S_FETCH;
          end
        end
        S_FETCH: begin
          if (rd_done) state_q <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (reg_free) state_q <= S_WAIT_DP;
        end
        S_WAIT_DP: begin
          if (in_dp_done) begin
            blk_q   <= blk_nxt[BLK_W-1:0];
            state_q <= more ? S_FETCH : S_FINISH;
          end
        end
        S_FINISH: begin
          if (reg_free) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Result skid register: load on datapath done, clear on accept.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      t_flat_q  <= '0;
      t_valid_q <= 1'b0;
    end else if (load) begin
      t_flat_q  <= in_t_flat;
      t_valid_q <= 1'b1;
    end else if (t_valid_q & in_t_ready) begin
      t_valid_q <= 1'b0;
    end
  end

  assign out_t_flat   = t_flat_q;
  assign out_t_valid  = t_valid_q;
  assign out_dp_start = launch;
  assign out_busy     = (state_q != S_IDLE);
  assign out_done     = done_q;

endmodule

// File: tb/tb_transform_block_sequencer.sv
// Randomised scoreboard bench for transform_block_sequencer.
// Models the register file, an echo datapath and a shell.
module tb_transform_block_sequencer;

  localparam int DATA_W = 9;
  localparam int RES_W  = 15;
  localparam int DIM    = 4;
  localparam int ADDR_W = 6;
  localparam int BLK_W  = 3;
  localparam int NE     = DIM * DIM;
  localparam int XW     = NE * DATA_W;
  localparam int TW     = NE * RES_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_start;
  logic [ADDR_W-1:0] in_base_addr;
  logic [BLK_W-1:0]  in_num_blocks;
  logic [ADDR_W-1:0] out_rf_addr;
  logic              out_rf_en;
  logic [DATA_W-1:0] in_rf_data = '0;
  logic [XW-1:0]     out_x_flat;
  logic              out_dp_start;
  logic              in_dp_done;
  logic [TW-1:0]     in_t_flat;
  logic [TW-1:0]     out_t_flat;
  logic              out_t_valid;
  logic              in_t_ready;
  logic              out_busy;
  logic              out_done;

  logic [DATA_W-1:0] mem [64];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [XW-1:0]     exp_x [$];
  logic [TW-1:0]     exp_t [$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int dp_seen = 0;
  int rdy_mode = 0;
  int lat = 3;
  logic spur_done = 1'b0;

  logic [XW-1:0] dp_x = '0;
  int            dp_cnt = 0;
  logic          dp_done_m = 1'b0;

  logic          hold_prev = 1'b0;
  logic [TW-1:0] prev_t = '0;

  transform_block_sequencer #(
    .DATA_W (DATA_W), .RES_W (RES_W), .DIM (DIM),
    .ADDR_W (ADDR_W), .BLK_W (BLK_W)
  ) dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_start      (in_start),
    .in_base_addr  (in_base_addr),
    .in_num_blocks (in_num_blocks),
    .out_rf_addr   (out_rf_addr),
    .out_rf_en     (out_rf_en),
    .in_rf_data    (in_rf_data),
    .out_x_flat    (out_x_flat),
    .out_dp_start  (out_dp_start),
    .in_dp_done    (in_dp_done),
    .in_t_flat     (in_t_flat),
    .out_t_flat    (out_t_flat),
    .out_t_valid   (out_t_valid),
    .in_t_ready    (in_t_ready),
    .out_busy      (out_busy),
    .out_done      (out_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {out_rf_addr, out_rf_en, out_dp_start,
                       out_t_valid, out_busy, out_done}, '0);
    chk({nm, "_x"}, out_x_flat, '0);
    chk({nm, "_t"}, out_t_flat, '0);
  endtask

  // Register file: one-cycle read latency.
  always @(posedge clk) begin
    if (out_rf_en) in_rf_data <= mem[out_rf_addr];
  end

  // Echo datapath: result = samples + 100 after 'lat' cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_cnt    <= 0;
      dp_done_m <= 1'b0;
    end else begin
      dp_done_m <= 1'b0;
      if (out_dp_start) begin
        dp_x   <= out_x_flat;
        dp_cnt <= lat;
      end else if (dp_cnt != 0) begin
        dp_cnt <= dp_cnt - 1;
        if (dp_cnt == 1) dp_done_m <= 1'b1;
      end
    end
  end

  always_comb begin
    in_t_flat = '0;
    for (int k = 0; k < NE; k++)
      in_t_flat[k*RES_W +: RES_W] =
        RES_W'(dp_x[k*DATA_W +: DATA_W]) + RES_W'(100);
  end

  assign in_dp_done = dp_done_m | spur_done;

  // Shell ready: 0 = always, 1 = stalled, else random.
  initial begin
    in_t_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: in_t_ready = 1'b1;
        1: in_t_ready = 1'b0;
        default: in_t_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_rf_en) begin
        if (exp_addr.size() == 0) chk("rf_en_unexpected", 1, 0);
        else chk("rf_addr", out_rf_addr, exp_addr.pop_front());
      end
      if (out_dp_start) begin
        dp_seen++;
        chk("dp_start_reg_free", out_t_valid & ~in_t_ready, 0);
        if (exp_x.size() == 0) chk("dp_start_unexpected", 1, 0);
        else chk("x_flat", out_x_flat, exp_x.pop_front());
      end
      if (hold_prev)
        chk("t_hold", {out_t_valid, out_t_flat}, {1'b1, prev_t});
      if (out_t_valid && in_t_ready) begin
        if (exp_t.size() == 0) chk("t_unexpected", 1, 0);
        else chk("t_flat", out_t_flat, exp_t.pop_front());
      end
      hold_prev = out_t_valid & ~in_t_ready;
      prev_t    = out_t_flat;
      if (out_done) done_cnt++;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic push_exp(input logic [ADDR_W-1:0] base, input int n);
    logic [XW-1:0] xv;
    logic [TW-1:0] tv;
    int ai;
    for (int b = 0; b < n; b++) begin
      xv = '0;
      tv = '0;
      for (int k = 0; k < NE; k++) begin
        ai = (int'(base) + b * NE + k) % 64;
        exp_addr.push_back(ADDR_W'(ai));
        xv[k*DATA_W +: DATA_W] = mem[ai];
        tv[k*RES_W +: RES_W] = RES_W'(mem[ai]) + RES_W'(100);
      end
      exp_x.push_back(xv);
      exp_t.push_back(tv);
    end
  endtask

  task automatic flush_exp();
    exp_addr.delete();
    exp_x.delete();
    exp_t.delete();
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input int n);
    @(posedge clk);
    #1;
    in_base_addr  = base;
    in_num_blocks = BLK_W'(n);
    in_start      = 1'b1;
    @(posedge clk);
    #1;
    in_start = 1'b0;
  endtask

  // mode: 0 ready, 2 random, 3 stall 40 cycles after first valid.
  task automatic run(input logic [ADDR_W-1:0] base, input int n,
                     input int latv, input int mode,
                     input bit tchk, input bit spur);
    int d0;
    int hold_c;
    push_exp(base, n);
    lat      = latv;
    rdy_mode = (mode == 3) ? 1 : mode;
    d0       = done_cnt;
    pulse_start(base, n);
    if (tchk) begin
      if (n == 0) begin
        @(negedge clk);
        chk("zero_done_c1", out_done, 0);
        @(negedge clk);
        chk("zero_done_c2", out_done, 1);
        chk("zero_busy_c2", out_busy, 0);
      end else begin
        for (int i = 1; i <= 18; i++) begin
          @(negedge clk);
          chk("rf_en_timing", out_rf_en, (i <= 16));
          chk("dp_start_timing", out_dp_start, (i == 18));
        end
      end
    end
    hold_c = -1;
    for (int c = 0; c < 4000 && done_cnt == d0; c++) begin
      @(negedge clk);
      if (spur) begin
        if (c == 4) begin
          in_start      = 1'b1;
          in_base_addr  = ~base;
          in_num_blocks = BLK_W'(5);
        end
        if (c == 5) in_start = 1'b0;
        if (c == 7) spur_done = 1'b1;
        if (c == 8) spur_done = 1'b0;
      end
      if (mode == 3) begin
        if (hold_c < 0 && out_t_valid) hold_c = c;
        else if (hold_c >= 0 && c - hold_c >= 40) rdy_mode = 0;
      end
    end
    chk("done_seen", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("queues_empty", exp_addr.size() + exp_x.size() + exp_t.size(), 0);
    chk("busy_idle", out_busy, 0);
    flush_exp();
    rdy_mode = 0;
  endtask

  task automatic reset_mid(input logic [ADDR_W-1:0] base);
    int d0;
    int s0;
    push_exp(base, 2);
    lat      = 8;
    rdy_mode = 0;
    d0       = done_cnt;
    s0       = dp_seen;
    pulse_start(base, 2);
    for (int c = 0; c < 200 && dp_seen == s0; c++) @(negedge clk);
    chk("rst_reach_wait", dp_seen != s0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    @(negedge clk);
    chk_zero("rst_hold");
    flush_exp();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", out_busy, 0);
  endtask

  task automatic mem_ramp();
    for (int i = 0; i < 64; i++) mem[i] = DATA_W'(i);
  endtask

  task automatic mem_rand();
    for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom_range(0, 511));
  endtask

  initial begin
    rst_n         = 1'b0;
    in_start      = 1'b0;
    in_base_addr  = '0;
    in_num_blocks = '0;
    mem_ramp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(6'd0, 1, 3, 0, 1'b1, 1'b0);
    run(6'd60, 1, 3, 0, 1'b0, 1'b0);
    mem_rand();
    run(ADDR_W'($urandom_range(0, 63)), 3, 4, 3, 1'b0, 1'b0);
    run(ADDR_W'($urandom_range(0, 63)), 0, 3, 0, 1'b1, 1'b0);
    run(ADDR_W'($urandom_range(0, 63)), 1, 2, 0, 1'b0, 1'b1);
    reset_mid(ADDR_W'($urandom_range(0, 63)));
    mem_ramp();
    run(6'd0, 1, 3, 0, 1'b1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      mem_rand();
      run(ADDR_W'($urandom_range(0, 63)), int'($urandom_range(1, 7)),
          int'($urandom_range(1, 6)), ($urandom_range(0, 1) != 0) ? 2 : 0,
          1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
